// File: rtl/trivium_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : trivium_ctrl
// Brief   : Session controller and two-channel round-robin byte scheduler
//           for an 8-bit-per-step Trivium keystream core.
// Rev     : 1.0  initial release
// ============================================================================
module trivium_ctrl #(
  parameter int INIT_STEPS = 144,
  parameter int MAX_BYTES  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_bit,
  input  logic        key_valid,
  input  logic [79:0] iv,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  dout,
  output logic        core_load,
  output logic [79:0] core_key,
  output logic [79:0] core_iv,
  output logic        core_init,
  output logic        core_step,
  input  logic [7:0]  core_ks,
  output logic        ready,
  output logic        rekey_req
);

  localparam int                  c_init_w    = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_STEPS - 1);
  localparam logic [16:0]         c_max_bytes = 17'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY_LOAD  = 3'd1,
    S_LOAD      = 3'd2,
    S_INIT      = 3'd3,
    S_READY     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;

  state_t              r_state;
  logic [79:0]         r_key_sr;
  logic [6:0]          r_bit_cnt;
  logic [79:0]         r_core_iv;
  logic [16:0]         r_byte_cnt;
  logic [c_init_w-1:0] r_init_cnt;
  logic                r_rr_ptr;
  logic                r_ack0;
  logic                r_ack1;
  logic [7:0]          r_dout;
  logic                r_core_load;
  logic                r_ready;
  logic                r_rekey_req;

  logic        w_grant_en;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [16:0] w_byte_cnt_inc;

  // A new key bit always pre-empts a grant in the same cycle.
  assign w_grant_en     = (r_state == S_READY) && !key_valid;
  assign w_elig0        = req0 && !r_ack0;
  assign w_elig1        = req1 && !r_ack1;
  assign w_gnt0         = w_grant_en && w_elig0 && (!w_elig1 || !r_rr_ptr);
  assign w_gnt1         = w_grant_en && w_elig1 && (!w_elig0 ||  r_rr_ptr);
  assign w_byte_cnt_inc = r_byte_cnt + 17'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_key_sr    <= '0;
      r_bit_cnt   <= '0;
      r_core_iv   <= '0;
      r_byte_cnt  <= '0;
      r_init_cnt  <= '0;
      r_rr_ptr    <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_dout      <= '0;
      r_core_load <= 1'b0;
      r_ready     <= 1'b0;
      r_rekey_req <= 1'b0;
    end else begin
      r_core_load <= 1'b0;
      r_ready     <= 1'b0;
      r_rekey_req <= 1'b0;
      r_ack0      <= w_gnt0;
      r_ack1      <= w_gnt1;

      if (key_valid) begin
        r_key_sr <= {r_key_sr[78:0], key_bit};
      end

      if (w_gnt0 || w_gnt1) begin
        r_dout     <= (w_gnt0 ? din0 : din1) ^ core_ks;
        r_byte_cnt <= w_byte_cnt_inc;
        r_rr_ptr   <= w_gnt0;
      end

      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_bit_cnt <= 7'd1;
            r_state   <= S_KEY_LOAD;
          end
        end

        S_KEY_LOAD: begin
          if (key_valid) begin
            if (r_bit_cnt == 7'd79) begin
              r_core_iv   <= iv;
              r_core_load <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 7'd1;
            end
          end
        end

        S_LOAD: begin
          r_byte_cnt <= '0;
          r_init_cnt <= '0;
          r_rr_ptr   <= 1'b0;
          if (key_valid) begin
            r_bit_cnt <= 7'd1;
            r_state   <= S_KEY_LOAD;
          end else begin
            r_state <= S_INIT;
          end
        end

        S_INIT: begin
          if (key_valid) begin
            r_bit_cnt <= 7'd1;
            r_state   <= S_KEY_LOAD;
          end else if (r_init_cnt == c_init_last) begin
            r_ready <= 1'b1;
            r_state <= S_READY;
          end else begin
            r_init_cnt <= r_init_cnt + c_init_w'(1);
          end
        end

        S_READY: begin
          if (key_valid) begin
            r_bit_cnt <= 7'd1;
            r_state   <= S_KEY_LOAD;
          end else if ((w_gnt0 || w_gnt1) && (w_byte_cnt_inc == c_max_bytes)) begin
            r_rekey_req <= 1'b1;
            r_state     <= S_EXHAUSTED;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_EXHAUSTED: begin
          if (key_valid) begin
            r_bit_cnt <= 7'd1;
            r_state   <= S_KEY_LOAD;
          end else begin
            r_rekey_req <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign dout      = r_dout;
  assign core_load = r_core_load;
  assign core_key  = r_key_sr;
  assign core_iv   = r_core_iv;
  assign core_init = (r_state == S_INIT) && !key_valid;
  assign core_step = w_gnt0 || w_gnt1;
  assign ready     = r_ready;
  assign rekey_req = r_rekey_req;

endmodule
`default_nettype wire

// File: tb/tb_trivium_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_trivium_ctrl
// Brief   : Scoreboard testbench for trivium_ctrl (short byte budget).
// Rev     : 1.0  initial release
// ============================================================================
module tb_trivium_ctrl;

  localparam int c_init_steps = 144;
  localparam int c_max_bytes  = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        key_bit   = 1'b0;
  logic        key_valid = 1'b0;
  logic [79:0] iv        = '0;
  logic        req0      = 1'b0;
  logic        req1      = 1'b0;
  logic [7:0]  din0      = '0;
  logic [7:0]  din1      = '0;
  logic [7:0]  core_ks   = '0;
  logic        ack0;
  logic        ack1;
  logic [7:0]  dout;
  logic        core_load;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_init;
  logic        core_step;
  logic        ready;
  logic        rekey_req;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] sb[$];   // {channel, expected dout}

  trivium_ctrl #(
    .INIT_STEPS (c_init_steps),
    .MAX_BYTES  (c_max_bytes)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .iv        (iv),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .ack0      (ack0),
    .ack1      (ack1),
    .dout      (dout),
    .core_load (core_load),
    .core_key  (core_key),
    .core_iv   (core_iv),
    .core_init (core_init),
    .core_step (core_step),
    .core_ks   (core_ks),
    .ready     (ready),
    .rekey_req (rekey_req)
  );

  always #5 clk = ~clk;

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_key(input logic [79:0] k, input int gap, input int first, input int nbits);
    for (int i = first; i < first + nbits; i++) begin
      key_valid = 1'b1;
      key_bit   = k[79 - i];
      drive_edge();
      key_valid = 1'b0;
      if (i != first + nbits - 1) repeat (gap) drive_edge();
    end
  endtask

  // Measures the INIT run; leaves at the negedge of the first non-init cycle.
  task automatic count_init(output int n, output int clash);
    n = 0;
    clash = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!core_init) break;
      n++;
      if (core_load || core_step) clash++;
    end
  endtask

  task automatic test_reset();
    logic [174:0] all_out;
    repeat (2) drive_edge();
    @(negedge clk);
    all_out = {ack0, ack1, dout, core_load, core_key, core_iv, core_init, core_step, ready, rekey_req};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    drive_edge();
    rst = 1'b1;
  endtask

  task automatic test_key_load();
    logic [79:0] k;
    logic [79:0] v;
    int n, clash;
    k = 80'h0123456789ABCDEF0123;
    v = 80'h13579BDF2468ACE0FFFF;
    iv = v;
    feed_key(k, 10, 0, 80);
    iv = '0;
    @(negedge clk);
    checks++;
    if (core_load !== 1'b1) begin errors++; $display("FAIL load_pulse: got %b, want 1", core_load); end
    checks++;
    if (core_key !== k) begin errors++; $display("FAIL core_key: got %h, want %h", core_key, k); end
    checks++;
    if (core_iv !== v) begin errors++; $display("FAIL core_iv: got %h, want %h", core_iv, v); end
    count_init(n, clash);
    checks++;
    if (n !== c_init_steps) begin errors++; $display("FAIL init_len: got %0d, want %0d", n, c_init_steps); end
    checks++;
    if (clash !== 0) begin errors++; $display("FAIL init_exclusive: got %0d clashes, want 0", clash); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_init: got %b, want 1", ready); end
    drive_edge();
  endtask

  task automatic test_single();
    logic [8:0] e;
    core_ks = 8'h3C;
    din0    = 8'h5A;
    req0    = 1'b1;
    sb.push_back({1'b0, 8'h66});
    @(negedge clk);
    checks++;
    if (core_step !== 1'b1) begin errors++; $display("FAIL single_step: got %b, want 1", core_step); end
    drive_edge();
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL single_ack: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({ack0, ack1, dout} !== {~e[8], e[8], e[7:0]}) begin
        errors++;
        $display("FAIL single_ack: got ack0=%b ack1=%b dout=%h, want ch%0d dout=%h", ack0, ack1, dout, e[8], e[7:0]);
      end
    end
    checks++;
    if (core_step !== 1'b0) begin errors++; $display("FAIL single_no_step: got %b, want 0", core_step); end
    drive_edge();
    @(negedge clk);
    checks++;
    if ({ack0, dout} !== {1'b0, 8'h66}) begin
      errors++; $display("FAIL dout_hold: got ack0=%b dout=%h, want 0/66", ack0, dout);
    end
    drive_edge();
  endtask

  task automatic test_held0();
    logic [8:0] e;
    int acks, steps;
    acks = 0; steps = 0;
    core_ks = 8'h0F;
    din0    = 8'hA5;
    req0    = 1'b1;
    sb.push_back({1'b0, 8'hAA});
    sb.push_back({1'b0, 8'hAA});
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req0 = 1'b0;
      @(negedge clk);
      if (core_step) steps++;
      if (ack0 || ack1) begin
        acks++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL held_ack: unexpected ack at cycle %0d", c);
        end else begin
          e = sb.pop_front();
          if ((ack0 && ack1) || ({ack1, dout} !== e)) begin
            errors++; $display("FAIL held_ack: got ack1=%b dout=%h, want %h", ack1, dout, e);
          end
        end
      end
      drive_edge();
    end
    checks++;
    if (acks !== 2) begin errors++; $display("FAIL held_acks: got %0d, want 2", acks); end
    checks++;
    if (steps !== 2) begin errors++; $display("FAIL held_steps: got %0d, want 2", steps); end
  endtask

  task automatic test_budget();
    logic [8:0] e;
    int acks, steps;
    acks = 0; steps = 0;
    core_ks = 8'hF0;
    din0    = 8'h11;
    din1    = 8'h22;
    req0    = 1'b1;
    req1    = 1'b1;
    sb.push_back({1'b1, 8'hD2});   // pointer sits on channel 1 after two ch0 grants
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (core_step) steps++;
      if (ack0 || ack1) begin
        acks++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL budget_ack: unexpected ack at cycle %0d", c);
        end else begin
          e = sb.pop_front();
          if ((ack0 && ack1) || ({ack1, dout} !== e)) begin
            errors++; $display("FAIL budget_ack: got ack1=%b dout=%h, want %h", ack1, dout, e);
          end
        end
      end
      drive_edge();
    end
    @(negedge clk);
    checks++;
    if (acks !== 1 || steps !== 1) begin
      errors++; $display("FAIL budget_count: got acks=%0d steps=%0d, want 1/1", acks, steps);
    end
    checks++;
    if ({rekey_req, ready, core_step} !== 3'b100) begin
      errors++; $display("FAIL exhausted: got rekey/ready/step=%b, want 100", {rekey_req, ready, core_step});
    end
    drive_edge();
  endtask

  task automatic test_rekey_alternate();
    logic [79:0] k;
    logic [8:0]  e;
    int n, clash, acks, steps, first_ack, last_ack;
    k = 80'hFEDCBA9876543210A5C3;
    acks = 0; steps = 0; first_ack = -1; last_ack = -1;
    key_valid = 1'b1;
    key_bit   = k[79];
    @(negedge clk);
    checks++;
    if ({rekey_req, core_step} !== 2'b10) begin
      errors++; $display("FAIL rekey_first_bit: got rekey/step=%b, want 10", {rekey_req, core_step});
    end
    drive_edge();
    key_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rekey_req !== 1'b0) begin errors++; $display("FAIL rekey_drop: got %b, want 0", rekey_req); end
    drive_edge();
    feed_key(k, 0, 1, 79);
    @(negedge clk);
    checks++;
    if ({core_load, core_key} !== {1'b1, k}) begin
      errors++; $display("FAIL rekey_load: got load=%b key=%h, want 1/%h", core_load, core_key, k);
    end
    count_init(n, clash);
    checks++;
    if (n !== c_init_steps || clash !== 0) begin
      errors++; $display("FAIL rekey_init: got len=%0d clash=%0d, want %0d/0", n, clash, c_init_steps);
    end
    sb.push_back({1'b0, 8'hE1});
    sb.push_back({1'b1, 8'hD2});
    sb.push_back({1'b0, 8'hE1});
    sb.push_back({1'b1, 8'hD2});
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        drive_edge();
        @(negedge clk);
      end
      if (core_step) steps++;
      if (ack0 || ack1) begin
        acks++;
        if (first_ack < 0) first_ack = c;
        last_ack = c;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL alt_ack: unexpected ack at cycle %0d", c);
        end else begin
          e = sb.pop_front();
          if ((ack0 && ack1) || ({ack1, dout} !== e)) begin
            errors++; $display("FAIL alt_ack: got ack1=%b dout=%h, want %h", ack1, dout, e);
          end
        end
      end
    end
    checks++;
    if (acks !== 4 || steps !== acks || (last_ack - first_ack) !== 3) begin
      errors++;
      $display("FAIL alt_rate: got acks=%0d steps=%0d span=%0d, want 4/4/3", acks, steps, last_ack - first_ack);
    end
    checks++;
    if ({rekey_req, ready} !== 2'b10) begin
      errors++; $display("FAIL alt_exhausted: got rekey/ready=%b, want 10", {rekey_req, ready});
    end
    drive_edge();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_abort_init();
    logic [79:0] k3;
    logic [79:0] k4;
    int n, clash;
    k3 = 80'h3C3C0F0F5555AAAA9696;
    k4 = 80'h8421FEDC0BAD5EED1234;
    feed_key(k3, 0, 0, 80);
    @(negedge clk);
    checks++;
    if (core_load !== 1'b1) begin errors++; $display("FAIL abort_load1: got %b, want 1", core_load); end
    n = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (core_init) n++;
    end
    drive_edge();
    key_valid = 1'b1;
    key_bit   = k4[79];
    @(negedge clk);
    checks++;
    if ({n, core_init, core_load} !== {32'd49, 2'b00}) begin
      errors++; $display("FAIL init_abort: got init_before=%0d init=%b load=%b, want 49/0/0", n, core_init, core_load);
    end
    drive_edge();
    key_valid = 1'b0;
    feed_key(k4, 0, 1, 79);
    @(negedge clk);
    checks++;
    if ({core_load, core_key} !== {1'b1, k4}) begin
      errors++; $display("FAIL abort_load2: got load=%b key=%h, want 1/%h", core_load, core_key, k4);
    end
    count_init(n, clash);
    checks++;
    if (n !== c_init_steps || clash !== 0 || ready !== 1'b1) begin
      errors++; $display("FAIL abort_init: got len=%0d clash=%0d ready=%b, want %0d/0/1", n, clash, ready, c_init_steps);
    end
    drive_edge();
  endtask

  task automatic test_async_reset();
    logic [174:0] all_out;
    logic [79:0]  k;
    k = 80'h00FF00FF00FF00FF00FF;
    din0 = 8'h77;
    req0 = 1'b1;
    @(negedge clk);
    checks++;
    if (core_step !== 1'b1) begin errors++; $display("FAIL arst_grant: got %b, want 1", core_step); end
    #2;
    rst = 1'b0;
    #1;
    all_out = {ack0, ack1, dout, core_load, core_key, core_iv, core_init, core_step, ready, rekey_req};
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL arst_clear: got %h, want 0", all_out); end
    drive_edge();
    req0 = 1'b0;
    @(negedge clk);
    all_out = {ack0, ack1, dout, core_load, core_key, core_iv, core_init, core_step, ready, rekey_req};
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL arst_held: got %h, want 0", all_out); end
    drive_edge();
    rst = 1'b1;
    drive_edge();
    feed_key(k, 0, 0, 80);
    @(negedge clk);
    checks++;
    if ({core_load, core_key, ready} !== {1'b1, k, 1'b0}) begin
      errors++; $display("FAIL arst_idle_rekey: got load=%b key=%h ready=%b, want 1/%h/0", core_load, core_key, ready, k);
    end
    drive_edge();
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_single();
    test_held0();
    test_budget();
    test_rekey_alternate();
    test_abort_init();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
